// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the receiver state encoding.
// UART_RX_PARITY_EN adds the PARITY state to rx_state_t.
package uart_pkg;
  localparam int OVERSAMPLE     = 16;
  localparam int START_MID      = 7;
  localparam int CTRL_DATA7_BIT = 15;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversampling tick, one pulse every dvsr+1 clocks.
// The divisor is captured on each wrap so a new value only takes effect at the next wrap.
module uart_baud_gen #(
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DVSR_WIDTH-1:0] i_dvsr,
  output logic                  o_tick
);
  logic [DVSR_WIDTH-1:0] r_cnt, r_lim;
  logic                  w_tick;
  assign w_tick = r_cnt == r_lim;
  assign o_tick = w_tick;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_lim <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_lim <= i_dvsr;
    end
  end
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: synchronised, 16x oversampled 7/8-bit UART receiver with done strobe.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DVSR_WIDTH = 11,
  parameter int DATA_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DVSR_WIDTH-1:0] i_dvsr,
  input  logic                  i_data_bits_7,
  input  logic                  i_rx,
`ifdef UART_RX_PARITY_EN
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  output logic                  o_parity_err,
`endif
  output logic [DATA_BITS-1:0]  o_dout,
  output logic                  o_rx_done_tick,
  output logic                  o_frame_err,
  output logic                  o_rx_busy
);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_MID  = 4'(START_MID);
  rx_state_t            r_state, w_state;
  logic [1:0]           r_sync;
  logic [3:0]           r_s, w_s;
  logic [NW-1:0]        r_n, w_n, w_nlast;
  logic [DATA_BITS-1:0] r_b, w_b, r_dout, w_dout, w_frame;
  logic                 r_n7, w_n7, r_done, w_done, r_ferr, w_ferr;
  logic                 w_rx_s, w_tick;
`ifdef UART_RX_PARITY_EN
  logic                 r_pen, w_pen, r_podd, w_podd, r_pbit, w_pbit, r_perr, w_perr;
`endif
  uart_baud_gen #(.DVSR_WIDTH(DVSR_WIDTH)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_dvsr (i_dvsr),
    .o_tick (w_tick)
  );
  assign w_rx_s  = r_sync[1];
  assign w_nlast = r_n7 ? NW'(DATA_BITS - 2) : NW'(DATA_BITS - 1);
  // In 7-bit mode the last shift leaves the data in the upper bits.
  assign w_frame = r_n7 ? {1'b0, r_b[DATA_BITS-1:1]} : r_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_n7    <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pen   <= 1'b0;
      r_podd  <= 1'b0;
      r_pbit  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_state <= w_state;
      r_s     <= w_s;
      r_n     <= w_n;
      r_b     <= w_b;
      r_n7    <= w_n7;
      r_dout  <= w_dout;
      r_done  <= w_done;
      r_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
      r_pen   <= w_pen;
      r_podd  <= w_podd;
      r_pbit  <= w_pbit;
      r_perr  <= w_perr;
`endif
    end
  end
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_b     = r_b;
    w_n7    = r_n7;
    w_dout  = r_dout;
    w_done  = 1'b0;
    w_ferr  = r_ferr;
`ifdef UART_RX_PARITY_EN
    w_pen   = r_pen;
    w_podd  = r_podd;
    w_pbit  = r_pbit;
    w_perr  = r_perr;
`endif
    case (r_state)
      RX_IDLE: if (!w_rx_s) begin
        w_state = RX_START;
        w_s     = '0;
        w_n7    = i_data_bits_7;
`ifdef UART_RX_PARITY_EN
        w_pen   = i_parity_en;
        w_podd  = i_parity_odd;
`endif
      end
      RX_START: if (w_tick) begin
        if (r_s == S_MID) begin
          w_state = w_rx_s ? RX_IDLE : RX_DATA;
          w_s     = '0;
          w_n     = '0;
        end else w_s = r_s + 4'd1;
      end
      RX_DATA: if (w_tick) begin
        if (r_s == S_LAST) begin
          w_s = '0;
          w_b = {w_rx_s, r_b[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          if (r_n == w_nlast) w_state = r_pen ? RX_PARITY : RX_STOP;
`else
          if (r_n == w_nlast) w_state = RX_STOP;
`endif
          else w_n = r_n + 1'b1;
        end else w_s = r_s + 4'd1;
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (w_tick) begin
        if (r_s == S_LAST) begin
          w_pbit  = w_rx_s;
          w_s     = '0;
          w_state = RX_STOP;
        end else w_s = r_s + 4'd1;
      end
`endif
      RX_STOP: if (w_tick) begin
        if (r_s == S_LAST) begin
          w_done  = 1'b1;
          w_ferr  = ~w_rx_s;
          w_dout  = w_frame;
`ifdef UART_RX_PARITY_EN
          w_perr  = r_pen & ((^w_frame ^ r_pbit) != r_podd);
`endif
          w_state = RX_IDLE;
        end else w_s = r_s + 4'd1;
      end
      default: w_state = RX_IDLE;
    endcase
  end
  always_comb begin
    o_dout         = r_dout;
    o_rx_done_tick = r_done;
    o_frame_err    = r_ferr;
    o_rx_busy      = r_state != RX_IDLE;
`ifdef UART_RX_PARITY_EN
    o_parity_err   = r_perr;
`endif
  end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: random UART frames against a queue-based frame model.
module tb_uart_rx_deserializer;
  logic        clk = 0, rst_n = 1, i_data_bits_7 = 0, i_rx = 1;
  logic [10:0] i_dvsr = 11'd3;
  logic [7:0]  o_dout;
  logic        o_rx_done_tick, o_frame_err, o_rx_busy;
`ifdef UART_RX_PARITY_EN
  logic        i_parity_en = 0, i_parity_odd = 0, o_parity_err;
  localparam bit PAR_BUILD = 1;
`else
  localparam bit PAR_BUILD = 0;
`endif
  typedef struct {logic [7:0] d; logic fe; logic pe;} exp_t;
  exp_t q[$];
  exp_t e_mon;
  int total = 0, bad = 0, strobes = 0, sent = 0, bit_clks, tick_clks;
  uart_rx_deserializer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_dvsr         (i_dvsr),
    .i_data_bits_7  (i_data_bits_7),
    .i_rx           (i_rx),
`ifdef UART_RX_PARITY_EN
    .i_parity_en    (i_parity_en),
    .i_parity_odd   (i_parity_odd),
    .o_parity_err   (o_parity_err),
`endif
    .o_dout         (o_dout),
    .o_rx_done_tick (o_rx_done_tick),
    .o_frame_err    (o_frame_err),
    .o_rx_busy      (o_rx_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && o_rx_done_tick) begin
    strobes++;
    if (q.size() == 0) chk("spurious_strobe", 1, 0);
    else begin
      e_mon = q.pop_front();
      chk("dout", o_dout, e_mon.d);
      chk("frame_err", o_frame_err, e_mon.fe);
`ifdef UART_RX_PARITY_EN
      chk("parity_err", o_parity_err, e_mon.pe);
`endif
    end
  end
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic send(input logic [7:0] d, input bit n7, input bit stop_ok,
                      input bit pen, input bit podd, input bit pbad);
    int   nb = n7 ? 7 : 8;
    logic p = podd ^ pbad;
    exp_t e;
    for (int k = 0; k < nb; k++) p ^= d[k];
    e.d = n7 ? (d & 8'h7f) : d;
    e.fe = !stop_ok;
    e.pe = pen & pbad;
    q.push_back(e);
    sent++;
    i_data_bits_7 = n7;
`ifdef UART_RX_PARITY_EN
    i_parity_en = pen;
    i_parity_odd = podd;
`endif
    @(posedge clk);
    i_rx = 0;
    wait_clks(bit_clks);
    i_data_bits_7 = 1'($urandom);
`ifdef UART_RX_PARITY_EN
    i_parity_en = 1'($urandom);
    i_parity_odd = 1'($urandom);
`endif
    for (int k = 0; k < nb; k++) begin
      i_rx = d[k];
      wait_clks(bit_clks);
    end
    if (pen) begin
      i_rx = p;
      wait_clks(bit_clks);
    end
    if (stop_ok) begin
      i_rx = 1;
      wait_clks(bit_clks);
    end else begin
      // Low long enough to be sampled as the stop bit, short enough that the re-armed start check rejects it.
      i_rx = 0;
      wait_clks(12 * tick_clks);
      i_rx = 1;
      wait_clks(2 * bit_clks);
    end
  endtask
  initial begin
    i_dvsr = 11'($urandom_range(3, 5));
    tick_clks = int'(i_dvsr) + 1;
    bit_clks = 16 * tick_clks;
    #2 rst_n = 0;
    wait_clks(5);
    @(negedge clk);
    chk("rst_dout", o_dout, 0);
    chk("rst_done", o_rx_done_tick, 0);
    chk("rst_ferr", o_frame_err, 0);
    chk("rst_busy", o_rx_busy, 0);
    rst_n = 1;
    wait_clks(20 * bit_clks);
    chk("idle_strobes", strobes, 0);
    chk("idle_busy", o_rx_busy, 0);
    send(8'h32, 0, 1, 0, 0, 0);
    send(8'h57, 0, 1, 0, 0, 0);
    send(8'hA5, 0, 1, 0, 0, 0);
    wait_clks(bit_clks);
    send(8'h41, 1, 1, 0, 0, 0);
    send(8'h67, 1, 1, 0, 0, 0);
    send(8'h3A, 1, 1, 0, 0, 0);
    wait_clks(bit_clks);
    @(posedge clk);
    i_rx = 0;
    wait_clks(3 * tick_clks);
    i_rx = 1;
    wait_clks(2 * bit_clks);
    chk("glitch_busy", o_rx_busy, 0);
    chk("glitch_strobes", strobes, sent);
    send(8'h79, 0, 0, 0, 0, 0);
    send(8'h79, 1, 1, 0, 0, 0);
    send(8'h12, 1, 1, 0, 0, 0);
    send(8'h6B, 1, 1, 0, 0, 0);
    send(8'h01, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom), 1'($urandom), ($urandom_range(0, 5) != 0),
           1'($urandom) & PAR_BUILD, 1'($urandom), 1'($urandom));
      wait_clks($urandom_range(0, 2) * bit_clks);
    end
    wait_clks(bit_clks);
    i_data_bits_7 = 0;
    @(posedge clk);
    i_rx = 0;
    wait_clks(bit_clks);
    for (int k = 0; k < 4; k++) begin
      i_rx = k[1];
      wait_clks(bit_clks);
    end
    i_rx = 0;
    wait_clks(bit_clks / 2);
    @(negedge clk);
    chk("frame_busy", o_rx_busy, 1);
    rst_n = 0;
    i_rx = 1;
    wait_clks(2);
    @(negedge clk);
    chk("midrst_dout", o_dout, 0);
    chk("midrst_busy", o_rx_busy, 0);
    chk("midrst_done", o_rx_done_tick, 0);
    rst_n = 1;
    wait_clks(12 * bit_clks);
    chk("abort_strobes", strobes, sent);
    send(8'h91, 0, 1, PAR_BUILD, 0, PAR_BUILD);
    for (int i = 0; i < 4 * bit_clks && q.size() != 0; i++) @(posedge clk);
    wait_clks(2 * bit_clks);
    chk("drained", q.size(), 0);
    chk("strobe_count", strobes, sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
